jk_ff_bank: RTL

Parametrised bank of WIDTH edge-triggered storage bits, each behaving as a JK, D, T or SR flip-flop depending on a shared run-time MODE.
It adds a synchronous active-low reset, clock enable, parallel load, sticky SR-illegal-input flags, and a saturating count of state-change edges.
It is the general-purpose register primitive for the sequential-logic exercises and small datapaths in this codebase.

---
 rtl/jk_ff_bank.sv | 93 +++++++++
 1 files changed

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH storage bits acting as JK, D, T or SR flip-flops under a shared MODE,
// with parallel load, sticky SR-illegal flags and a saturating count of state changes.
module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_BAR,
    output logic             CHANGED,
    output logic [WIDTH-1:0] SR_ERR,
    output logic [CNT_W-1:0] CHG_CNT
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] sr_err_r;
    logic             changed_r;
    logic [CNT_W-1:0] chg_cnt_r;

    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] err_set_s;
    logic [WIDTH-1:0] err_next_s;
    logic             q_diff_s;
    logic             cnt_sat_s;

    // Next-state selection: load beats enable, enable gates the mode-driven update.
    always_comb begin
        q_next_s  = q_r;
        err_set_s = {WIDTH{1'b0}};
        if (LOAD) begin
            q_next_s = LOAD_VAL;
        end else if (!EN) begin
            q_next_s = q_r;
        end else begin
            case (mode_e'(MODE))
                MODE_JK: q_next_s = (J & ~q_r) | (~K & q_r);
                MODE_D:  q_next_s = J;
                MODE_T:  q_next_s = q_r ^ J;
                // S=R=1 falls into the hold term and raises the per-bit error instead.
                MODE_SR: begin
                    q_next_s  = (J & ~K) | (q_r & ~(J ^ K));
                    err_set_s = J & K;
                end
                default: q_next_s = q_r;
            endcase
        end
        err_next_s = (ERR_CLR ? {WIDTH{1'b0}} : sr_err_r) | err_set_s;
        q_diff_s   = (q_next_s != q_r);
        cnt_sat_s  = &chg_cnt_r;
    end

    // State, change flag and saturating change counter, all under synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_r       <= RST_VAL;
            sr_err_r  <= {WIDTH{1'b0}};
            changed_r <= 1'b0;
            chg_cnt_r <= {CNT_W{1'b0}};
        end else begin
            q_r       <= q_next_s;
            sr_err_r  <= err_next_s;
            changed_r <= q_diff_s;
            if (q_diff_s && !cnt_sat_s) begin
                chg_cnt_r <= chg_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                chg_cnt_r <= chg_cnt_r;
            end
        end
    end

    assign Q       = q_r;
    assign Q_BAR   = ~q_r;
    assign CHANGED = changed_r;
    assign SR_ERR  = sr_err_r;
    assign CHG_CNT = chg_cnt_r;

endmodule
